// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone slave-side interconnect.
package wb_mux_pkg;

  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 32;
  localparam int unsigned SW        = 4;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned TMR_W     = 16;

  localparam logic [DW-1:0] ERR_WORD_DEF = 32'hDEAD_BEEF;

  // CSR byte offsets inside the CSR window
  localparam int unsigned CSR_OFF_STATUS   = 32'h0;
  localparam int unsigned CSR_OFF_LAST_ERR = 32'h4;
  localparam int unsigned CSR_OFF_IRQ_EN   = 32'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Latched upstream request
  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_slave_mux_if.sv
// Upstream (SoC) and downstream (user cores) Wishbone signal bundle.
interface wb_slave_mux_if #(
  parameter int unsigned N_SLV = 4
);
  import wb_mux_pkg::*;

  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [SW-1:0]          wbs_sel_i;
  logic [AW-1:0]          wbs_adr_i;
  logic [DW-1:0]          wbs_dat_i;
  logic                   wbs_ack_o;
  logic [DW-1:0]          wbs_dat_o;

  logic [N_SLV-1:0]       m_cyc_o;
  logic [N_SLV-1:0]       m_stb_o;
  logic                   m_we_o;
  logic [SW-1:0]          m_sel_o;
  logic [AW-1:0]          m_adr_o;
  logic [DW-1:0]          m_dat_o;
  logic [DW*N_SLV-1:0]    m_dat_i;
  logic [N_SLV-1:0]       m_ack_i;

  // Interconnect side
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    input  m_dat_i, m_ack_i
  );

  // SoC master plus downstream cores, seen from outside the interconnect
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    output m_dat_i, m_ack_i
  );

endinterface

// File: rtl/wb_mux_csr.sv
// Error status CSRs: error counter, pending flag, last error address, IRQ enable.
module wb_mux_csr
  import wb_mux_pkg::*;
#(
  parameter int unsigned WIN_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIN_BITS-1:0]  off,
  input  logic                 wr_clr_pend,
  input  logic                 wr_clr_cnt,
  input  logic                 wr_irq_en,
  input  logic                 err,
  input  logic [AW-1:0]        err_adr,
  output logic [DW-1:0]        rdata_c,
  output logic                 irq_o
);

  logic [ERR_CNT_W-1:0] err_cnt, err_cnt_d;
  logic                 pend, pend_d;
  logic                 irq_en, irq_en_d;
  logic [AW-1:0]        last_err_adr;

  // Next-state: writes first, then a new error so that set wins over clear
  always_comb begin
    err_cnt_d = err_cnt;
    pend_d    = pend;
    irq_en_d  = irq_en;
    if (wr_en && off == WIN_BITS'(CSR_OFF_STATUS)) begin
      if (wr_clr_pend) pend_d    = 1'b0;
      if (wr_clr_cnt)  err_cnt_d = '0;
    end
    if (wr_en && off == WIN_BITS'(CSR_OFF_IRQ_EN)) irq_en_d = wr_irq_en;
    if (err) begin
      pend_d = 1'b1;
      if (err_cnt_d != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
    end
  end

  // CSR registers and registered interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt      <= '0;
      pend         <= 1'b0;
      irq_en       <= 1'b0;
      last_err_adr <= '0;
      irq_o        <= 1'b0;
    end else begin
      err_cnt <= err_cnt_d;
      pend    <= pend_d;
      irq_en  <= irq_en_d;
      irq_o   <= pend_d & irq_en_d;
      if (err) last_err_adr <= err_adr;
    end
  end

  // Read mux; unknown offsets read as zero
  always_comb begin
    rdata_c = '0;
    if (off == WIN_BITS'(CSR_OFF_STATUS))   rdata_c = {23'b0, pend, err_cnt};
    if (off == WIN_BITS'(CSR_OFF_LAST_ERR)) rdata_c = last_err_adr;
    if (off == WIN_BITS'(CSR_OFF_IRQ_EN))   rdata_c = {31'b0, irq_en};
  end

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone classic interconnect: window decode, single-transaction forwarding, bus timeout.
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int unsigned   N_SLV     = 4,
  parameter logic [31:0]   BASE_ADDR = 32'h3000_0000,
  parameter int unsigned   WIN_BITS  = 16,
  parameter int unsigned   TIMEOUT   = 255,
  parameter logic [31:0]   ERR_WORD  = ERR_WORD_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  wb_slave_mux_if.slave    bus,
  output logic             irq_o
);

  localparam int unsigned IDX_W   = $clog2(N_SLV + 1);
  localparam int unsigned TOP_LSB = WIN_BITS + IDX_W;

  state_e             state;
  wb_req_t            req_q;
  logic [TMR_W-1:0]   timer;
  logic [N_SLV-1:0]   m_cyc_q;
  logic [N_SLV-1:0]   m_stb_q;
  logic               ack_q;
  logic [DW-1:0]      rdat_q;

  logic [IDX_W-1:0]   idx_c;
  logic               base_hit_c, slave_hit_c, csr_hit_c, req_c;
  logic               ack_sel_c, tmo_c, err_c, csr_we_c;
  logic [N_SLV-1:0]   onehot_c;
  logic [DW-1:0]      sdat_c, csr_rdata_c;
  logic [AW-1:0]      err_adr_c;

  // Address decode of the live upstream request
  assign idx_c       = bus.wbs_adr_i[WIN_BITS +: IDX_W];
  assign base_hit_c  = bus.wbs_adr_i[AW-1:TOP_LSB] == BASE_ADDR[AW-1:TOP_LSB];
  assign slave_hit_c = base_hit_c && (idx_c < IDX_W'(N_SLV));
  assign csr_hit_c   = base_hit_c && (idx_c == IDX_W'(N_SLV));
  assign req_c       = (state == IDLE) && bus.wbs_cyc_i && bus.wbs_stb_i;
  assign onehot_c    = N_SLV'(1) << idx_c;

  // Only the slave currently holding cyc may complete the transfer
  assign ack_sel_c = |(bus.m_ack_i & m_cyc_q);
  assign tmo_c     = (state == FWD) && bus.wbs_cyc_i && !ack_sel_c &&
                     (timer == TMR_W'(TIMEOUT));
  assign err_c     = (req_c && !slave_hit_c && !csr_hit_c) || tmo_c;
  assign err_adr_c = (state == IDLE) ? bus.wbs_adr_i : req_q.adr;
  assign csr_we_c  = req_c && csr_hit_c && bus.wbs_we_i;

  // Read data slice of the selected slave
  always_comb begin
    sdat_c = '0;
    for (int k = 0; k < int'(N_SLV); k++) begin
      if (m_cyc_q[k]) sdat_c = sdat_c | bus.m_dat_i[DW*k +: DW];
    end
  end

  wb_mux_csr #(.WIN_BITS(WIN_BITS)) u_csr (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .wr_en       (csr_we_c),
    .off         (bus.wbs_adr_i[WIN_BITS-1:0]),
    .wr_clr_pend (bus.wbs_dat_i[8]),
    .wr_clr_cnt  (bus.wbs_dat_i[9]),
    .wr_irq_en   (bus.wbs_dat_i[0]),
    .err         (err_c),
    .err_adr     (err_adr_c),
    .rdata_c     (csr_rdata_c),
    .irq_o       (irq_o)
  );

  // Transaction FSM with timer and registered bus outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      req_q   <= '0;
      timer   <= '0;
      m_cyc_q <= '0;
      m_stb_q <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_c) begin
            req_q <= '{we: bus.wbs_we_i, sel: bus.wbs_sel_i,
                       adr: bus.wbs_adr_i, dat: bus.wbs_dat_i};
            timer <= '0;
            if (slave_hit_c) begin
              state   <= FWD;
              m_cyc_q <= onehot_c;
              m_stb_q <= onehot_c;
            end else begin
              state  <= RESP;
              ack_q  <= 1'b1;
              rdat_q <= csr_hit_c ? csr_rdata_c : ERR_WORD;
            end
          end
        end
        FWD: begin
          if (!bus.wbs_cyc_i) begin
            state   <= IDLE;
            m_cyc_q <= '0;
            m_stb_q <= '0;
          end else if (ack_sel_c || tmo_c) begin
            state   <= RESP;
            ack_q   <= 1'b1;
            rdat_q  <= ack_sel_c ? sdat_c : ERR_WORD;
            m_cyc_q <= '0;
            m_stb_q <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdat_q;
  assign bus.m_cyc_o   = m_cyc_q;
  assign bus.m_stb_o   = m_stb_q;
  assign bus.m_we_o    = req_q.we;
  assign bus.m_sel_o   = req_q.sel;
  assign bus.m_adr_o   = req_q.adr;
  assign bus.m_dat_o   = req_q.dat;

endmodule
